// File: rtl/flame_renderer_if.sv
`default_nettype none
// ==== flame_renderer_if : bomb control, raster and sprite bus for flame_renderer -- rev 1.0 ====
interface flame_renderer_if #(
  parameter int TILE = 28
);
  logic       frame_clk;
  logic       trigger;
  logic [4:0] bomb_col;
  logic [4:0] bomb_row;
  logic [2:0] blast_range;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] sprite_index [0:TILE-1][0:TILE-1];
  logic       busy;
  logic       done;
  logic       flame_on;
  logic [7:0] flame_idx;

  modport master (
    output frame_clk, trigger, bomb_col, bomb_row, blast_range, DrawX, DrawY, sprite_index,
    input  busy, done, flame_on, flame_idx
  );

  modport slave (
    input  frame_clk, trigger, bomb_col, bomb_row, blast_range, DrawX, DrawY, sprite_index,
    output busy, done, flame_on, flame_idx
  );
endinterface
`default_nettype wire

// File: rtl/flame_renderer.sv
`default_nettype none
// ==== flame_renderer : timed explosion cross drawn over the VGA raster -- rev 1.0 ====
module flame_renderer #(
  parameter int TILE        = 28,
  parameter int GRID_X0     = 40,
  parameter int GRID_Y0     = 30,
  parameter int GRID_W      = 15,
  parameter int GRID_H      = 13,
  parameter int MAX_RANGE   = 4,
  parameter int BURN_FRAMES = 30,
  parameter int FADE_FRAMES = 16
) (
  input wire              Clk,
  input wire              Reset,
  flame_renderer_if.slave bus
);
  localparam int c_pw = $clog2(TILE);
  localparam int c_fw = $clog2((BURN_FRAMES > FADE_FRAMES) ? BURN_FRAMES : FADE_FRAMES);

  localparam logic [9:0]      c_x0        = 10'(GRID_X0);
  localparam logic [9:0]      c_y0        = 10'(GRID_Y0);
  localparam logic [9:0]      c_tile      = 10'(TILE);
  localparam logic [9:0]      c_gw        = 10'(GRID_W);
  localparam logic [9:0]      c_gh        = 10'(GRID_H);
  localparam logic [2:0]      c_max       = 3'(MAX_RANGE);
  localparam logic [c_fw-1:0] c_burn_last = c_fw'(BURN_FRAMES - 1);
  localparam logic [c_fw-1:0] c_fade_last = c_fw'(FADE_FRAMES - 1);
  localparam logic [c_fw-1:0] c_one       = c_fw'(1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_burn = 2'd1;
  localparam logic [1:0] c_fade = 2'd2;

  logic [1:0]      r_state;
  logic [c_fw-1:0] r_fcnt;
  logic [4:0]      r_col;
  logic [4:0]      r_row;
  logic [2:0]      r_range;
  logic            r_done;
  logic            r_frame_q;
  logic            w_tick;

  assign w_tick = bus.frame_clk & ~r_frame_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= c_idle;
      r_fcnt    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_range   <= '0;
      r_done    <= 1'b0;
      r_frame_q <= 1'b0;
    end else begin
      r_frame_q <= bus.frame_clk;
      r_done    <= 1'b0;
      case (r_state)
        c_idle: begin
          if (bus.trigger) begin
            r_col   <= bus.bomb_col;
            r_row   <= bus.bomb_row;
            r_range <= (bus.blast_range > c_max) ? c_max : bus.blast_range;
            r_fcnt  <= '0;
            r_state <= c_burn;
          end
        end
        c_burn: begin
          if (w_tick) begin
            if (r_fcnt == c_burn_last) begin
              r_fcnt  <= '0;
              r_state <= c_fade;
            end else begin
              r_fcnt <= r_fcnt + c_one;
            end
          end
        end
        c_fade: begin
          if (w_tick) begin
            if (r_fcnt == c_fade_last) begin
              r_fcnt  <= '0;
              r_state <= c_idle;
              r_done  <= 1'b1;
            end else begin
              r_fcnt <= r_fcnt + c_one;
            end
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Fade blinks 4 frames on, 4 frames off.
  logic w_visible;
  assign w_visible = (r_state == c_burn) || ((r_state == c_fade) && !r_fcnt[2]);

  logic [9:0]        w_rx, w_ry, w_tx, w_ty;
  logic              w_in_grid;
  logic signed [5:0] w_dx, w_dy;
  logic [5:0]        w_adx, w_ady;
  logic              w_vert, w_horiz;

  assign w_rx      = bus.DrawX - c_x0;
  assign w_ry      = bus.DrawY - c_y0;
  assign w_tx      = w_rx / c_tile;
  assign w_ty      = w_ry / c_tile;
  assign w_in_grid = (bus.DrawX >= c_x0) && (bus.DrawY >= c_y0) && (w_tx < c_gw) && (w_ty < c_gh);
  assign w_dx      = 6'(w_tx) - {1'b0, r_col};
  assign w_dy      = 6'(w_ty) - {1'b0, r_row};
  assign w_adx     = w_dx[5] ? 6'(-w_dx) : 6'(w_dx);
  assign w_ady     = w_dy[5] ? 6'(-w_dy) : 6'(w_dy);
  assign w_vert    = (w_dx == 6'sd0) && (w_ady <= {3'b000, r_range});
  assign w_horiz   = (w_dy == 6'sd0) && (w_adx <= {3'b000, r_range});

  logic            r_hit;
  logic            r_harm;
  logic [c_pw-1:0] r_px;
  logic [c_pw-1:0] r_py;
  logic            r_on;
  logic [7:0]      r_idx;
  logic [7:0]      w_idx;

  // Horizontal arms reuse the vertical sprite by transposing it.
  assign w_idx = r_harm ? bus.sprite_index[r_px][r_py] : bus.sprite_index[r_py][r_px];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit  <= 1'b0;
      r_harm <= 1'b0;
      r_px   <= '0;
      r_py   <= '0;
      r_on   <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_hit  <= w_in_grid & (w_vert | w_horiz);
      r_harm <= w_horiz & ~w_vert;
      r_px   <= c_pw'(w_rx % c_tile);
      r_py   <= c_pw'(w_ry % c_tile);
      r_on   <= w_visible & r_hit & (w_idx != 8'd0);
      r_idx  <= (w_visible & r_hit & (w_idx != 8'd0)) ? w_idx : 8'd0;
    end
  end

  assign bus.busy      = (r_state != c_idle);
  assign bus.done      = r_done;
  assign bus.flame_on  = r_on;
  assign bus.flame_idx = r_idx;
endmodule
`default_nettype wire
